// File: rtl/game_life_controller.sv
// game_life_controller: keeps score, lives and level, and sequences the death,
// respawn and level-clear pauses that freeze the movers and strobe their resets.
module game_life_controller #(
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 5,
    parameter int EXTRA_LIFE_SCORE = 10000,
    parameter int DEATH_FRAMES     = 96,
    parameter int ANIM_DIV         = 8,
    parameter int READY_FRAMES     = 120,
    parameter int CLEAR_FRAMES     = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [3:0]  ghost_hit,
    input  logic [3:0]  ghost_eaten,
    input  logic        pellet_eaten,
    input  logic        power_pellet,
    input  logic        level_clear,
    input  logic        restart,
    output logic [19:0] score,
    output logic [2:0]  lives,
    output logic [7:0]  level,
    output logic        freeze,
    output logic        soft_reset,
    output logic        new_map,
    output logic [3:0]  death_anim_frame,
    output logic        game_over
);
    typedef enum logic [2:0] {PLAY, DYING, RESPAWN, LEVEL_CLEAR, GAME_OVER} state_t;
    state_t      state, state_next;
    logic [7:0]  frame_cnt, anim_step;
    logic [1:0]  combo, combo_next;
    logic        bonus_given;
    logic [11:0] add;
    logic [20:0] sum;
    logic [19:0] score_next;
    logic        dying_done, ready_done, clear_done, timed, map_set, soft_set;

    assign dying_done = frame_cnt == 8'(DEATH_FRAMES);
    assign ready_done = frame_cnt == 8'(READY_FRAMES);
    assign clear_done = frame_cnt == 8'(CLEAR_FRAMES);
    assign timed      = state inside {DYING, RESPAWN, LEVEL_CLEAR};
    assign map_set    = (state == LEVEL_CLEAR && clear_done) || (state == GAME_OVER && restart);
    assign soft_set   = (state == DYING && dying_done && lives != 3'd1) || map_set;
    assign sum        = {1'b0, score} + {9'd0, add};
    assign score_next = (sum > 21'd999999) ? 20'd999999 : sum[19:0];

    // Ghosts are scored in ascending index so each one sees the combo left by the previous.
    always_comb begin
        add = (pellet_eaten ? 12'd10 : 12'd0) + (power_pellet ? 12'd50 : 12'd0);
        combo_next = combo;
        for (int i = 0; i < 4; i++) begin
            if (ghost_eaten[i]) begin
                add = add + (12'd200 << combo_next);
                combo_next = (combo_next == 2'd3) ? 2'd3 : combo_next + 2'd1;
            end
        end
        combo_next = power_pellet ? 2'd0 : combo_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PLAY:        state_next = |ghost_hit ? DYING : level_clear ? LEVEL_CLEAR : PLAY;
            DYING:       state_next = !dying_done ? DYING : (lives == 3'd1) ? GAME_OVER : RESPAWN;
            RESPAWN:     state_next = ready_done ? PLAY : RESPAWN;
            LEVEL_CLEAR: state_next = clear_done ? RESPAWN : LEVEL_CLEAR;
            GAME_OVER:   state_next = restart ? RESPAWN : GAME_OVER;
            default:     state_next = RESPAWN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RESPAWN;
            score       <= 20'd0;
            lives       <= 3'(START_LIVES);
            level       <= 8'd0;
            combo       <= 2'd0;
            bonus_given <= 1'b0;
            frame_cnt   <= 8'd0;
            soft_reset  <= 1'b0;
            new_map     <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= (state_next != state) ? 8'd0 : (timed && frame_tick) ? frame_cnt + 8'd1 : frame_cnt;
            soft_reset <= soft_set ? 1'b1 : frame_tick ? 1'b0 : soft_reset;
            new_map    <= map_set ? 1'b1 : frame_tick ? 1'b0 : new_map;
            case (state)
                PLAY: begin
                    score <= score_next;
                    combo <= combo_next;
                    if (!bonus_given && score_next >= 20'(EXTRA_LIFE_SCORE)) begin
                        bonus_given <= 1'b1;
                        lives       <= (lives >= 3'(MAX_LIVES)) ? lives : lives + 3'd1;
                    end
                end
                DYING: if (dying_done) lives <= lives - 3'd1;
                LEVEL_CLEAR: if (clear_done) begin
                    level <= level + 8'd1;
                    combo <= 2'd0;
                end
                GAME_OVER: if (restart) begin
                    score       <= 20'd0;
                    lives       <= 3'(START_LIVES);
                    level       <= 8'd0;
                    bonus_given <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign anim_step = frame_cnt / 8'(ANIM_DIV);

    always_comb begin
        freeze           = state != PLAY;
        game_over        = state == GAME_OVER;
        death_anim_frame = (state != DYING) ? 4'd0 : (anim_step > 8'd11) ? 4'd11 : anim_step[3:0];
    end
endmodule
